// File: rtl/barcode_overlay.sv
// Barcode scan-line overlay: draws NUM_LINES marker rows over the binarised
// image. The scan status is latched once per frame so the marker colour is
// stable within a frame. Includes a post-detection hold timer and blinking
// markers while searching. All outputs are registered (1 clk latency).
module barcode_overlay #(
   parameter int                    NUM_LINES      = 3,
   parameter logic [10*NUM_LINES-1:0] LINE_Y       = {10'd132, 10'd102, 10'd82},
   parameter int                    LINE_THICK     = 1,
   parameter int                    X_START        = 0,
   parameter int                    X_END          = 479,
   parameter int                    HOLD_FRAMES    = 30,
   parameter int                    BLINK_PERIOD   = 16,
   parameter bit                    VS_ACTIVE_HIGH = 1'b1,
   parameter logic [23:0]           COLOR_OK       = 24'h00ff00,
   parameter logic [23:0]           COLOR_FAIL     = 24'hff0000,
   parameter logic [23:0]           COLOR_FG       = 24'h000000,
   parameter logic [23:0]           COLOR_BG       = 24'hffffff
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [9:0]           x_in,
   input  logic [9:0]           y_in,
   input  logic                 scan_en,
   input  logic                 in_hs,
   input  logic                 in_vs,
   input  logic                 in_de,
   input  logic                 in_data,
   input  logic [NUM_LINES-1:0] line_mask,
   output logic                 out_hs,
   output logic                 out_vs,
   output logic                 out_de,
   output logic [23:0]          out_data,
   output logic                 scan_ok
);

   typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

   localparam logic [7:0]  HOLD_INIT  = 8'(HOLD_FRAMES - 1);
   localparam bit          BLINK_EN   = (BLINK_PERIOD != 0);
   localparam logic [7:0]  BLINK_LAST = 8'(BLINK_PERIOD - 1);
   localparam logic [7:0]  BLINK_HALF = 8'(BLINK_PERIOD / 2);
   localparam logic [10:0] X_LO       = 11'(X_START);
   localparam logic [10:0] X_HI_EXCL  = 11'(X_END) + 11'd1;

   state_t      state_reg, state_next;
   logic [7:0]  hold_reg, hold_next;
   logic [7:0]  blink_reg, blink_next;
   logic        seen_reg;
   logic        vs_d_reg;
   logic        primed_reg;   // low only on the first cycle after reset
   logic        fs;
   logic        any_scan;
   logic        blink_on;
   logic        x_in_range;
   logic        hit;
   logic [NUM_LINES-1:0] line_hit;
   logic [23:0] pix_next;

   // Frame start: edge into the active vsync level, suppressed right after reset.
   assign fs = primed_reg &&
               (VS_ACTIVE_HIGH ? (in_vs && !vs_d_reg) : (!in_vs && vs_d_reg));

   // The fs cycle's scan_en still belongs to the frame that is ending.
   assign any_scan = seen_reg | scan_en;
   assign blink_on = !BLINK_EN || (blink_reg < BLINK_HALF);

   // Column window; the +1 form keeps the lower bound check valid when X_START is 0.
   assign x_in_range = (({1'b0, x_in} + 11'd1) > X_LO) && ({1'b0, x_in} < X_HI_EXCL);

   // One comparator pair per marker line; 11-bit upper bound avoids wrap at row 1023.
   for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
      localparam logic [10:0] Y_LO      = {1'b0, LINE_Y[10*gi +: 10]};
      localparam logic [10:0] Y_HI_EXCL = Y_LO + 11'(LINE_THICK);
      assign line_hit[gi] = line_mask[gi] && x_in_range &&
                            (({1'b0, y_in} + 11'd1) > Y_LO) &&
                            ({1'b0, y_in} < Y_HI_EXCL);
   end

   assign hit = |line_hit;

   // Lock/hold/blink next-state, evaluated only on a frame start.
   always_comb begin
      state_next = state_reg;
      hold_next  = hold_reg;
      blink_next = blink_reg;
      if (fs) begin
         if (BLINK_EN)
            blink_next = (blink_reg == BLINK_LAST) ? 8'd0 : blink_reg + 8'd1;
         case (state_reg)
            SEARCH: begin
               if (any_scan) begin
                  state_next = LOCKED;
                  hold_next  = HOLD_INIT;
               end
            end
            LOCKED: begin
               if (any_scan) begin
                  hold_next = HOLD_INIT;
               end else if (hold_reg == 8'd0) begin
                  state_next = SEARCH;
                  blink_next = 8'd0;
               end else begin
                  hold_next = hold_reg - 8'd1;
               end
            end
         endcase
      end
   end

   // Output pixel: marker colour over hit rows, otherwise the binarised image.
   always_comb begin
      pix_next = 24'h000000;
      if (in_de) begin
         if (hit && (state_reg == LOCKED || blink_on))
            pix_next = (state_reg == LOCKED) ? COLOR_OK : COLOR_FAIL;
         else
            pix_next = in_data ? COLOR_FG : COLOR_BG;
      end
   end

   // State, frame bookkeeping and all registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= SEARCH;
         hold_reg   <= 8'd0;
         blink_reg  <= 8'd0;
         seen_reg   <= 1'b0;
         vs_d_reg   <= 1'b0;
         primed_reg <= 1'b0;
         out_hs     <= 1'b0;
         out_vs     <= 1'b0;
         out_de     <= 1'b0;
         out_data   <= 24'h000000;
         scan_ok    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         hold_reg   <= hold_next;
         blink_reg  <= blink_next;
         seen_reg   <= fs ? 1'b0 : (seen_reg | scan_en);
         vs_d_reg   <= in_vs;
         primed_reg <= 1'b1;
         out_hs     <= in_hs;
         out_vs     <= in_vs;
         out_de     <= in_de;
         out_data   <= pix_next;
         scan_ok    <= (state_next == LOCKED);
      end
   end

endmodule

// File: tb/tb_barcode_overlay.sv
// Directed, table-driven bench for barcode_overlay. A second instance with
// LINE_THICK=2 shares all inputs to cover marker thickness.
module tb_barcode_overlay;

   localparam logic [23:0] RED   = 24'hff0000;
   localparam logic [23:0] GREEN = 24'h00ff00;
   localparam logic [23:0] BLACK = 24'h000000;
   localparam logic [23:0] WHITE = 24'hffffff;
   localparam logic [23:0] NONE  = 24'h000000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  x_in, y_in;
   logic        scan_en, in_hs, in_vs, in_de, in_data;
   logic [2:0]  line_mask;
   logic        out_hs, out_vs, out_de, scan_ok;
   logic [23:0] out_data;
   logic        out_hs2, out_vs2, out_de2, scan_ok2;
   logic [23:0] out_data2;

   int n_pass = 0;
   int n_total = 0;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   barcode_overlay dut (
      .clk(clk), .rst_n(rst_n), .x_in(x_in), .y_in(y_in), .scan_en(scan_en),
      .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de), .in_data(in_data),
      .line_mask(line_mask), .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de),
      .out_data(out_data), .scan_ok(scan_ok)
   );

   barcode_overlay #(.LINE_THICK(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .x_in(x_in), .y_in(y_in), .scan_en(scan_en),
      .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de), .in_data(in_data),
      .line_mask(line_mask), .out_hs(out_hs2), .out_vs(out_vs2), .out_de(out_de2),
      .out_data(out_data2), .scan_ok(scan_ok2)
   );

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic        de;
      logic        d;
      logic [2:0]  mask;
      logic [23:0] exp;
      logic [23:0] exp2;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Timing outputs must equal the inputs seen at the previous edge.
   logic e_hs, e_vs, e_de;
   always @(posedge clk) begin
      if (mon_en) begin
         e_hs = rst_n ? in_hs : 1'b0;
         e_vs = rst_n ? in_vs : 1'b0;
         e_de = rst_n ? in_de : 1'b0;
         #1;
         chk("hs_delay", {23'd0, out_hs}, {23'd0, e_hs});
         chk("vs_delay", {23'd0, out_vs}, {23'd0, e_vs});
         chk("de_delay", {23'd0, out_de}, {23'd0, e_de});
      end
   end

   // One frame start: a cycle with vsync high, then a cycle low.
   task automatic frame_start(input logic se);
      in_de = 1'b0; in_vs = 1'b1; in_hs = 1'b1; scan_en = se;
      tick();
      in_vs = 1'b0; in_hs = 1'b0; scan_en = 1'b0;
      tick();
   endtask

   task automatic pix(input string name, input logic [9:0] x, input logic [9:0] y,
                      input logic d, input logic [23:0] exp, input logic [23:0] exp2);
      x_in = x; y_in = y; in_de = 1'b1; in_data = d; line_mask = 3'b111;
      tick();
      chk(name, out_data, exp);
      chk({name, "_thick2"}, out_data2, exp2);
      in_de = 1'b0;
   endtask

   initial begin
      // in SEARCH with blink_cnt=0: markers red
      vecs[0]  = '{10'd10,  10'd82,  1'b1, 1'b1, 3'b111, RED,   RED};
      vecs[1]  = '{10'd10,  10'd83,  1'b1, 1'b0, 3'b111, WHITE, RED};
      vecs[2]  = '{10'd10,  10'd84,  1'b1, 1'b0, 3'b111, WHITE, WHITE};
      vecs[3]  = '{10'd10,  10'd50,  1'b1, 1'b1, 3'b111, BLACK, BLACK};
      vecs[4]  = '{10'd10,  10'd50,  1'b1, 1'b0, 3'b111, WHITE, WHITE};
      vecs[5]  = '{10'd10,  10'd82,  1'b0, 1'b1, 3'b111, NONE,  NONE};
      vecs[6]  = '{10'd10,  10'd102, 1'b1, 1'b0, 3'b101, WHITE, WHITE};
      vecs[7]  = '{10'd10,  10'd102, 1'b1, 1'b1, 3'b111, RED,   RED};
      vecs[8]  = '{10'd480, 10'd82,  1'b1, 1'b0, 3'b111, WHITE, WHITE};
      vecs[9]  = '{10'd479, 10'd82,  1'b1, 1'b1, 3'b111, RED,   RED};
      vecs[10] = '{10'd0,   10'd132, 1'b1, 1'b1, 3'b111, RED,   RED};
      vecs[11] = '{10'd10,  10'd133, 1'b1, 1'b1, 3'b111, BLACK, RED};
      vecs[12] = '{10'd10,  10'd81,  1'b1, 1'b0, 3'b111, WHITE, WHITE};
      vecs[13] = '{10'd10,  10'd82,  1'b1, 1'b0, 3'b110, WHITE, WHITE};
      vecs[14] = '{10'd10,  10'd101, 1'b1, 1'b1, 3'b111, BLACK, BLACK};

      rst_n = 1'b0; x_in = 10'd10; y_in = 10'd50; scan_en = 1'b0;
      in_hs = 1'b0; in_vs = 1'b1; in_de = 1'b1; in_data = 1'b1; line_mask = 3'b111;
      tick();
      mon_en = 1'b1;

      // reset held with active data on the inputs
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset_data", out_data, NONE);
         chk("reset_de", {23'd0, out_de}, 24'd0);
         chk("reset_scan_ok", {23'd0, scan_ok}, 24'd0);
      end

      // first cycle after release: vsync already high must not act as frame start
      rst_n = 1'b1; scan_en = 1'b1;
      tick();
      chk("no_fs_after_reset", {23'd0, scan_ok}, 24'd0);
      chk("first_pixel", out_data, BLACK);
      scan_en = 1'b0;

      // mid-frame reset clears the pending seen flag
      rst_n = 1'b0; in_vs = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         x_in = vecs[i].x; y_in = vecs[i].y; in_de = vecs[i].de;
         in_data = vecs[i].d; line_mask = vecs[i].mask;
         tick();
         $display("vec %0d: x=%0d y=%0d de=%0b d=%0b mask=%b -> %h / %h", i,
                  vecs[i].x, vecs[i].y, vecs[i].de, vecs[i].d, vecs[i].mask,
                  out_data, out_data2);
         chk($sformatf("vec%0d", i), out_data, vecs[i].exp);
         chk($sformatf("vec%0d_thick2", i), out_data2, vecs[i].exp2);
      end

      // blink: visible through blink_cnt=7, hidden at 8
      frame_start(1'b0);
      chk("seen_cleared_by_reset", {23'd0, scan_ok}, 24'd0);
      for (int i = 0; i < 6; i++) frame_start(1'b0);
      pix("blink7_shown", 10'd10, 10'd82, 1'b0, RED, RED);
      frame_start(1'b0);
      pix("blink8_hidden", 10'd10, 10'd82, 1'b0, WHITE, WHITE);

      // one-cycle scan_en pulse mid-frame: lock only at the next frame start
      scan_en = 1'b1;
      tick();
      scan_en = 1'b0;
      chk("pulse_no_early_lock", {23'd0, scan_ok}, 24'd0);
      pix("pre_lock_row102", 10'd10, 10'd102, 1'b0, WHITE, WHITE);
      chk("still_search", {23'd0, scan_ok}, 24'd0);
      frame_start(1'b0);
      chk("lock_at_fs", {23'd0, scan_ok}, 24'd1);
      pix("locked_row102", 10'd10, 10'd102, 1'b0, GREEN, GREEN);
      pix("locked_row101", 10'd10, 10'd101, 1'b0, WHITE, WHITE);

      // hold: 29 more frame starts stay locked, the 30th drops
      for (int i = 1; i < 30; i++) begin
         frame_start(1'b0);
         chk($sformatf("hold_fs%0d", i), {23'd0, scan_ok}, 24'd1);
      end
      frame_start(1'b0);
      chk("hold_expired", {23'd0, scan_ok}, 24'd0);
      pix("unlock_red", 10'd10, 10'd82, 1'b0, RED, RED);
      for (int i = 0; i < 7; i++) frame_start(1'b0);
      pix("blink_restart7", 10'd10, 10'd82, 1'b0, RED, RED);
      frame_start(1'b0);
      pix("blink_restart8", 10'd10, 10'd82, 1'b0, WHITE, WHITE);

      // scan_en only on the frame-start cycle: locks now, new frame not seen
      frame_start(1'b1);
      chk("fs_scan_lock", {23'd0, scan_ok}, 24'd1);
      for (int i = 1; i < 30; i++) frame_start(1'b0);
      chk("fs_scan_hold_last", {23'd0, scan_ok}, 24'd1);
      frame_start(1'b0);
      chk("fs_scan_seen_clear", {23'd0, scan_ok}, 24'd0);

      mon_en = 1'b0;
      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
